sobel_frame_sched: RTL and testbench

Frame-granular scheduler that shares one Sobel edge-detection engine between two pixel-stream sources. The Sobel engine has no stall or enable input and must see one pixel every clock for a full frame. This block grants the engine to one source per frame using round-robin arbitration, and re-initialises the engine through its reset between frames. It aborts a frame cleanly on stream underrun or protocol error, and marks which engine output cycles carry valid edge pixels.

---
 rtl/sobel_frame_sched.sv | 143 ++++++++++++++
 tb/tb_sobel_frame_sched.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sched.sv
// sobel_frame_sched: shares one Sobel engine between two pixel sources.
// The engine is granted to one source per frame (round-robin), and it is held
// in reset between frames. It also marks which engine output cycles carry valid
// edge pixels. A frame is aborted on an underrun or a misplaced SOF.
module sobel_frame_sched #(
  parameter int W = 720,
  parameter int H = 540
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [1:0]      src_valid_i,
  input  logic [1:0]      src_sof_i,
  input  logic [1:0][7:0] src_pixel_i,
  output logic [1:0]      src_ready_o,
  output logic            eng_rst_o,
  output logic [7:0]      eng_pixel_o,
  input  logic [7:0]      eng_sobel_i,
  output logic            out_valid_o,
  output logic            out_sof_o,
  output logic            out_src_o,
  output logic [7:0]      out_pixel_o,
  output logic            frame_done_o,
  output logic            err_underrun_o,
  output logic            err_sof_o
);

  localparam int NPIX  = W * H;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] FILL_PIX = CNT_W'(2 * W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             g_q, g_d;
  logic             frame_done_q, frame_done_d;
  logic             err_underrun_q, err_underrun_d;
  logic             err_sof_q, err_sof_d;

  logic [1:0] req_s;
  logic       cur_valid_s;
  logic       cur_sof_s;
  logic       streaming_s;

  assign req_s       = src_valid_i & src_sof_i & {2{en_i}};
  assign cur_valid_s = src_valid_i[g_q];
  assign cur_sof_s   = src_sof_i[g_q];
  assign streaming_s = (state_q == STREAM);

  // State, counter, arbitration pointer and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      prio_q         <= 1'b0;
      g_q            <= 1'b0;
      frame_done_q   <= 1'b0;
      err_underrun_q <= 1'b0;
      err_sof_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prio_q         <= prio_d;
      g_q            <= g_d;
      frame_done_q   <= frame_done_d;
      err_underrun_q <= err_underrun_d;
      err_sof_q      <= err_sof_d;
    end
  end

  // Next-state logic: grant in IDLE, one ARM cycle, then stream or abort.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prio_d         = prio_q;
    g_d            = g_q;
    frame_done_d   = 1'b0;
    err_underrun_d = err_underrun_q;
    err_sof_d      = err_sof_q;
    case (state_q)
      IDLE: begin
        if (req_s != 2'b00) begin
          g_d     = (req_s == 2'b11) ? prio_q : req_s[1];
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (!cur_valid_s) begin
          // Engine cannot stall: a missing pixel kills the frame.
          err_underrun_d = 1'b1;
          state_d        = IDLE;
          prio_d         = ~g_q;
          cnt_d          = '0;
        end else if (cur_sof_s != (cnt_q == '0)) begin
          // SOF must appear on the first pixel and nowhere else.
          err_sof_d = 1'b1;
          state_d   = IDLE;
          prio_d    = ~g_q;
          cnt_d     = '0;
        end else if (cnt_q == LAST_PIX) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
          prio_d       = ~g_q;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The engine is held in reset whenever no frame is armed or streaming.
  assign eng_rst_o   = (state_q == IDLE);
  assign src_ready_o = streaming_s ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign eng_pixel_o = streaming_s ? src_pixel_i[g_q] : 8'd0;

  // The first two lines only fill the engine line buffers.
  assign out_valid_o    = streaming_s & cur_valid_s & (cnt_q >= FILL_PIX);
  assign out_sof_o      = out_valid_o & (cnt_q == FILL_PIX);
  assign out_src_o      = g_q;
  assign out_pixel_o    = eng_sobel_i;
  assign frame_done_o   = frame_done_q;
  assign err_underrun_o = err_underrun_q;
  assign err_sof_o      = err_sof_q;

endmodule

// File: tb/tb_sobel_frame_sched.sv
// Self-checking bench for sobel_frame_sched with W=8, H=6 and a fake engine
// whose output is the input pixel XOR 8'h5A.
module tb_sobel_frame_sched;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int FILL = 2 * W;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [1:0]      src_valid;
  logic [1:0]      src_sof;
  logic [1:0][7:0] src_pixel;
  logic [1:0]      src_ready_o;
  logic            eng_rst_o;
  logic [7:0]      eng_pixel_o;
  logic [7:0]      eng_sobel;
  logic            out_valid_o, out_sof_o, out_src_o;
  logic [7:0]      out_pixel_o;
  logic            frame_done_o, err_underrun_o, err_sof_o;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       src;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic grant_q[$];
  int   gap_q[$];
  int   gaprst_q[$];

  int errors = 0;
  int checks = 0;
  int rdy0, rdy1, ov_cnt, done_cnt;
  int gap, gaprst;
  bit in_gap;
  logic prev_eng_rst = 1'b1;

  sobel_frame_sched #(.W(W), .H(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .src_valid_i   (src_valid),
    .src_sof_i     (src_sof),
    .src_pixel_i   (src_pixel),
    .src_ready_o   (src_ready_o),
    .eng_rst_o     (eng_rst_o),
    .eng_pixel_o   (eng_pixel_o),
    .eng_sobel_i   (eng_sobel),
    .out_valid_o   (out_valid_o),
    .out_sof_o     (out_sof_o),
    .out_src_o     (out_src_o),
    .out_pixel_o   (out_pixel_o),
    .frame_done_o  (frame_done_o),
    .err_underrun_o(err_underrun_o),
    .err_sof_o     (err_sof_o)
  );

  assign eng_sobel = eng_pixel_o ^ 8'h5A;

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int s, input int k);
    return 8'((k * 3 + s * 100 + 7) & 255);
  endfunction

  // Monitor: scoreboard compare on valid output, plus activity statistics.
  always @(negedge clk) begin
    if (src_ready_o[0]) rdy0++;
    if (src_ready_o[1]) rdy1++;
    if (frame_done_o) done_cnt++;
    if (out_valid_o) begin
      ov_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out_valid with nothing expected, out_pixel=%0h", out_pixel_o);
      end else begin
        mon_e = sb.pop_front();
        if ({out_pixel_o, out_sof_o, out_src_o} !== {mon_e.pix, mon_e.sof, mon_e.src}) begin
          errors++;
          $display("FAIL sb_pixel: got pix=%0h sof=%0b src=%0b, expected pix=%0h sof=%0b src=%0b",
                   out_pixel_o, out_sof_o, out_src_o, mon_e.pix, mon_e.sof, mon_e.src);
        end
      end
    end
    if (!eng_rst_o && prev_eng_rst) grant_q.push_back(out_src_o);
    prev_eng_rst = eng_rst_o;
    if (src_ready_o != 2'b00) begin
      if (in_gap && gap > 0) begin
        gap_q.push_back(gap);
        gaprst_q.push_back(gaprst);
      end
      in_gap = 1'b1;
      gap    = 0;
      gaprst = 0;
    end else if (in_gap) begin
      gap++;
      if (eng_rst_o) gaprst++;
    end
  end

  task automatic clear_stats();
    rdy0 = 0; rdy1 = 0; ov_cnt = 0; done_cnt = 0;
    in_gap = 1'b0; gap = 0; gaprst = 0;
    grant_q.delete(); gap_q.delete(); gaprst_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1;
    src_valid = 2'b00; src_sof = 2'b00; src_pixel = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
  endtask

  // Source model: sends nframes frames back to back, optionally dropping
  // valid (first frame only) or re-asserting SOF (first frame only).
  task automatic drive_src(input int s, input int nframes, input int drop_at,
                           input int resof_at, output int first_wait);
    first_wait = -1;
    for (int f = 0; f < nframes; f++) begin
      int k, waitc, pk;
      bit fin, drop;
      k = 0; waitc = 0; pk = -1; fin = 1'b0;
      while (!fin) begin
        drop = (f == 0) && (k == drop_at);
        src_valid[s] = !drop;
        src_sof[s]   = (k == 0) || ((f == 0) && (k == resof_at));
        src_pixel[s] = pix(s, k);
        if (!drop && k >= FILL && k != pk) begin
          sb.push_back({pix(s, k) ^ 8'h5A, (k == FILL), 1'(s)});
          pk = k;
        end
        @(negedge clk);
        if (drop) begin
          fin = 1'b1;
        end else if (src_ready_o[s]) begin
          if (f == 0 && k == 0) first_wait = waitc;
          if (f == 0 && k == resof_at) fin = 1'b1;
          else begin
            k++;
            if (k == NPIX) fin = 1'b1;
          end
        end else begin
          waitc++;
          if (waitc > 2000) begin
            checks++; errors++;
            $display("FAIL drive_timeout: src %0d stuck at pixel %0d", s, k);
            fin = 1'b1;
            f = nframes;
          end
        end
        @(posedge clk); #1;
        if (drop) begin
          checks++;
          if (eng_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_eng_rst: eng_rst=%0b, expected 1", eng_rst_o);
          end
        end
      end
    end
    src_valid[s] = 1'b0;
    src_sof[s]   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    src_valid = 2'b00; src_sof = 2'b00; src_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({eng_rst_o, src_ready_o, eng_pixel_o} !== {1'b1, 2'b00, 8'd0}) begin
      errors++;
      $display("FAIL reset_engine: eng_rst=%0b ready=%0b pixel=%0h, expected 1/00/0",
               eng_rst_o, src_ready_o, eng_pixel_o);
    end
    checks++;
    if ({out_valid_o, out_sof_o, out_src_o, frame_done_o, err_underrun_o, err_sof_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid/sof/src/done/eu/es=%b, expected 000000",
               {out_valid_o, out_sof_o, out_src_o, frame_done_o, err_underrun_o, err_sof_o});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    int fw;
    clear_stats();
    drive_src(0, 1, -1, -1, fw);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (fw !== 2) begin errors++; $display("FAIL grant_latency: waited %0d cycles, expected 2", fw); end
    checks++;
    if (rdy0 !== NPIX || rdy1 !== 0) begin
      errors++; $display("FAIL single_ready: ready0=%0d ready1=%0d, expected %0d/0", rdy0, rdy1, NPIX);
    end
    checks++;
    if (ov_cnt !== NPIX - FILL) begin
      errors++; $display("FAIL single_out_valid: got %0d, expected %0d", ov_cnt, NPIX - FILL);
    end
    checks++;
    if (done_cnt !== 1 || out_src_o !== 1'b0) begin
      errors++; $display("FAIL single_done: done=%0d src=%0b, expected 1/0", done_cnt, out_src_o);
    end
  endtask

  task automatic test_back_to_back();
    int fw0, fw1;
    int exp_g[4] = '{0, 1, 0, 1};
    apply_reset();
    clear_stats();
    fork
      drive_src(0, 2, -1, -1, fw0);
      drive_src(1, 2, -1, -1, fw1);
    join
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grant_q.size()) begin
        errors++; $display("FAIL b2b_grant%0d: missing, expected %0d", i, exp_g[i]);
      end else if (grant_q[i] !== 1'(exp_g[i])) begin
        errors++; $display("FAIL b2b_grant%0d: got %0b, expected %0d", i, grant_q[i], exp_g[i]);
      end
    end
    checks++;
    if (gap_q.size() !== 3) begin
      errors++; $display("FAIL b2b_gap_count: got %0d gaps, expected 3", gap_q.size());
    end
    for (int i = 0; i < gap_q.size(); i++) begin
      checks++;
      if (gap_q[i] !== 2 || gaprst_q[i] !== 1) begin
        errors++;
        $display("FAIL b2b_gap%0d: len=%0d rst=%0d, expected 2/1", i, gap_q[i], gaprst_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 4) begin errors++; $display("FAIL b2b_done: got %0d, expected 4", done_cnt); end
  endtask

  task automatic test_underrun();
    int fw, fa, fb;
    int exp_g[4] = '{0, 1, 0, 1};
    apply_reset();
    clear_stats();
    drive_src(0, 1, -1, -1, fw);
    fork
      drive_src(1, 2, 20, -1, fa);
      begin
        int t;
        t = 0;
        while (!src_ready_o[1] && t < 200) begin @(posedge clk); #1; t++; end
        drive_src(0, 1, -1, -1, fb);
      end
    join
    repeat (3) @(posedge clk); #1;
    checks++;
    if (err_underrun_o !== 1'b1 || err_sof_o !== 1'b0) begin
      errors++; $display("FAIL underrun_flags: eu=%0b es=%0b, expected 1/0", err_underrun_o, err_sof_o);
    end
    checks++;
    if (done_cnt !== 3) begin errors++; $display("FAIL underrun_done: got %0d, expected 3", done_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grant_q.size()) begin
        errors++; $display("FAIL underrun_grant%0d: missing, expected %0d", i, exp_g[i]);
      end else if (grant_q[i] !== 1'(exp_g[i])) begin
        errors++; $display("FAIL underrun_grant%0d: got %0b, expected %0d", i, grant_q[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_sof_error();
    int fw;
    clear_stats();
    drive_src(0, 2, -1, 10, fw);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (err_sof_o !== 1'b1 || err_underrun_o !== 1'b1) begin
      errors++; $display("FAIL sof_flags: es=%0b eu=%0b, expected 1/1", err_sof_o, err_underrun_o);
    end
    checks++;
    if (done_cnt !== 1 || grant_q.size() !== 2) begin
      errors++; $display("FAIL sof_abort: done=%0d grants=%0d, expected 1/2", done_cnt, grant_q.size());
    end
    drive_src(1, 1, -1, -1, fw);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (err_sof_o !== 1'b1 || err_underrun_o !== 1'b1 || done_cnt !== 2) begin
      errors++;
      $display("FAIL sticky_flags: es=%0b eu=%0b done=%0d, expected 1/1/2", err_sof_o, err_underrun_o, done_cnt);
    end
  endtask

  task automatic test_enable();
    int fw, bad;
    clear_stats();
    en = 1'b0;
    bad = 0;
    src_valid[0] = 1'b1; src_sof[0] = 1'b1; src_pixel[0] = pix(0, 0);
    repeat (10) begin
      @(negedge clk);
      if (eng_rst_o !== 1'b1 || src_ready_o !== 2'b00) bad++;
    end
    @(posedge clk); #1;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL en_hold: %0d granted cycles, expected 0", bad); end
    fork
      drive_src(0, 1, -1, -1, fw);
      begin
        en = 1'b1;
        repeat (20) @(posedge clk);
        #1 en = 1'b0;
      end
    join
    bad = 0;
    src_valid[0] = 1'b1; src_sof[0] = 1'b1; src_pixel[0] = pix(0, 0);
    repeat (10) begin
      @(negedge clk);
      if (eng_rst_o !== 1'b1 || src_ready_o !== 2'b00) bad++;
    end
    @(posedge clk); #1;
    src_valid = 2'b00; src_sof = 2'b00;
    checks++;
    if (done_cnt !== 1 || grant_q.size() !== 1 || bad !== 0) begin
      errors++;
      $display("FAIL en_midframe: done=%0d grants=%0d bad=%0d, expected 1/1/0", done_cnt, grant_q.size(), bad);
    end
    en = 1'b1;
  endtask

  task automatic test_rst_midframe();
    int k, wc, pk, fw;
    k = 0; wc = 0; pk = -1;
    while (k < 30 && wc < 200) begin
      src_valid[0] = 1'b1; src_sof[0] = (k == 0); src_pixel[0] = pix(0, k);
      if (k >= FILL && k != pk) begin
        sb.push_back({pix(0, k) ^ 8'h5A, (k == FILL), 1'b0});
        pk = k;
      end
      @(negedge clk);
      if (src_ready_o[0]) k++;
      else wc++;
      @(posedge clk); #1;
    end
    checks++;
    if (k !== 30) begin errors++; $display("FAIL rst_setup: reached pixel %0d, expected 30", k); end
    clear_stats();
    rst = 1'b1; src_valid = 2'b00; src_sof = 2'b00;
    #1;
    checks++;
    if ({eng_rst_o, src_ready_o, eng_pixel_o, out_valid_o, out_sof_o} !== {1'b1, 2'b00, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async_engine: eng_rst=%0b ready=%0b pixel=%0h valid=%0b sof=%0b",
               eng_rst_o, src_ready_o, eng_pixel_o, out_valid_o, out_sof_o);
    end
    checks++;
    if ({out_src_o, frame_done_o, err_underrun_o, err_sof_o} !== 4'b0) begin
      errors++;
      $display("FAIL rst_async_flags: src/done/eu/es=%b, expected 0000",
               {out_src_o, frame_done_o, err_underrun_o, err_sof_o});
    end
    @(posedge clk); #1 rst = 1'b0;
    drive_src(0, 1, -1, -1, fw);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done_cnt !== 1 || fw !== 2 || grant_q.size() !== 1) begin
      errors++;
      $display("FAIL rst_recover: done=%0d wait=%0d grants=%0d, expected 1/2/1", done_cnt, fw, grant_q.size());
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_sof_error();
    test_enable();
    test_rst_midframe();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected pixels never produced", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
